adsr_env: RTL and testbench
===========================

ADSR_ENV -- requirements
Module: adsr_env

Interface
REQ-001 SHALL have parameter ENV_W, default 8, envelope output width in bits.
REQ-002 SHALL have parameter FRAC_W, default 8, fractional accumulator bits below the envelope; ACC_W = ENV_W+FRAC_W.
REQ-003 SHALL have parameter RETRIG_ZERO, default 0; 1 = clear level to 0 on retrigger, 0 = attack continues from the current level.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Port: clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 Port: rst_n  in  1  asynchronous active-low reset.
REQ-007 Port: ce  in  1  clock enable; state advances only on clk edges with ce=1.
REQ-008 Port: trig  in  1  gate; high = note held.
REQ-009 Port: ai  in  ACC_W  attack increment per ce step.
REQ-010 Port: di  in  ACC_W  decay decrement per ce step.
REQ-011 Port: s  in  ENV_W  sustain level.
REQ-012 Port: ri  in  ACC_W  release decrement per ce step.
REQ-013 Port: envelope  out  ENV_W  registered, equals acc[ACC_W-1:FRAC_W].
REQ-014 Port: phase  out  3  current state: 0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE.
REQ-015 Port: active  out  1  high when phase != IDLE.
REQ-016 Port: done  out  1  one-clk pulse when RELEASE reaches 0.

Function
REQ-017 SHALL keep an ACC_W-bit accumulator acc; MAX = all ones, SUS = {s, FRAC_W zeros}, sampled live each ce step.
REQ-018 SHALL register trig as trig_q on ce steps only; rise = trig & ~trig_q evaluated on ce steps; trig changes between ce steps are seen only at the next ce step.
REQ-019 Priority per ce step: rise, then trig=0 release, then normal phase update.
REQ-020 On rise in any phase: phase -> ATTACK; acc -> 0 if RETRIG_ZERO=1, else acc unchanged that step.
REQ-021 trig=0 in ATTACK, DECAY or SUSTAIN: phase -> RELEASE, acc unchanged that step.
REQ-022 IDLE: acc held at 0.
REQ-023 ATTACK: if ai=0 or acc+ai >= MAX (ACC_W+1-bit compare), acc -> MAX and phase -> DECAY; else acc += ai.
REQ-024 DECAY: if di=0 or acc <= SUS+di (no wrap), acc -> SUS and phase -> SUSTAIN; else acc -= di.
REQ-025 SUSTAIN: acc -> SUS every ce step (tracks s changes); phase stays until trig=0 or rise.
REQ-026 RELEASE: if ri=0 or acc <= ri, acc -> 0, phase -> IDLE, done=1 for that clk; else acc -= ri.
REQ-027 SHALL never wrap: no overflow above MAX, no underflow below 0.
REQ-028 s = all ones: DECAY completes on its first ce step; s=0 with trig held: SUSTAIN at 0, not IDLE.
REQ-029 envelope, phase, active SHALL reflect the acc/phase update one clk after the ce edge (registered, no combinational path from inputs).
REQ-030 ce=0: all registers hold; done=0.

Reset
REQ-031 rst_n=0 SHALL immediately force acc=0, trig_q=0, phase=IDLE, envelope=0, active=0, done=0, including mid-envelope.
REQ-032 After rst_n release, trig already high SHALL count as a rise at the first ce step.

Verification (ENV_W=8, FRAC_W=8, ce every 4th clk)
REQ-033 ai=0x0500, trig held -> ATTACK ends at acc=0xFFFF on 52nd ce step, envelope=0xFF, phase=DECAY.
REQ-034 di=0x0A00, s=0x40 from 0xFFFF -> SUSTAIN on 20th decay ce step, envelope=0x40 held while trig=1.
REQ-035 ri=0x0100 from 0x4000, trig=0 -> envelope 0 and IDLE on 64th ce step, single-clk done pulse, active=0.
REQ-036 trig falls mid-ATTACK at envelope 0x80 -> RELEASE from 0x80; re-raise mid-RELEASE -> ATTACK from current level (RETRIG_ZERO=0), from 0 (RETRIG_ZERO=1).
REQ-037 ai=di=ri=0 -> MAX, SUS, 0 reached in one ce step each.
REQ-038 rst_n pulsed low mid-DECAY, asynchronously between edges -> all outputs 0 and phase IDLE without waiting for clk.

Source files
------------

// File: rtl/adsr_env.sv
// ADSR envelope generator: fixed-point accumulator walked through attack/decay/sustain/release on clock-enable steps.
// Outputs are registered one clk after the ce edge; no backpressure, ce gates all state advance.
module adsr_env #(
  parameter int ENV_W       = 8,
  parameter int FRAC_W      = 8,
  parameter bit RETRIG_ZERO = 1'b0,
  localparam int ACC_W      = ENV_W + FRAC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             trig,
  input  logic [ACC_W-1:0] ai,
  input  logic [ACC_W-1:0] di,
  input  logic [ENV_W-1:0] s,
  input  logic [ACC_W-1:0] ri,
  output logic [ENV_W-1:0] envelope,
  output logic [2:0]       phase,
  output logic             active,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } phase_t;

  localparam logic [ACC_W-1:0] MAX = {ACC_W{1'b1}};

  phase_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             trig_q, trig_d;
  logic             done_q, done_d;

  logic [ACC_W-1:0] sus;
  logic [ACC_W:0]   att_sum;
  logic [ACC_W:0]   dec_lim;
  logic             rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      trig_q  <= trig_d;
      done_q  <= done_d;
    end
  end

  // Sums carry one extra bit so the saturation compares can never wrap.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    trig_d  = trig_q;
    done_d  = 1'b0;
    sus     = {s, {FRAC_W{1'b0}}};
    att_sum = {1'b0, acc_q} + {1'b0, ai};
    dec_lim = {1'b0, sus} + {1'b0, di};
    rise    = trig & ~trig_q;

    if (ce) begin
      trig_d = trig;
      if (rise) begin
        state_d = ATTACK;
        if (RETRIG_ZERO) acc_d = '0;
      end else if (!trig && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
        state_d = RELEASE;
      end else begin
        case (state_q)
          IDLE: acc_d = '0;
          ATTACK: begin
            if (ai == '0 || att_sum >= {1'b0, MAX}) begin
              acc_d   = MAX;
              state_d = DECAY;
            end else begin
              acc_d = att_sum[ACC_W-1:0];
            end
          end
          DECAY: begin
            if (di == '0 || {1'b0, acc_q} <= dec_lim) begin
              acc_d   = sus;
              state_d = SUSTAIN;
            end else begin
              acc_d = acc_q - di;
            end
          end
          SUSTAIN: acc_d = sus;
          RELEASE: begin
            if (ri == '0 || acc_q <= ri) begin
              acc_d   = '0;
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              acc_d = acc_q - ri;
            end
          end
          default: begin
            acc_d   = '0;
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  assign envelope = acc_q[ACC_W-1:FRAC_W];
  assign phase    = state_q;
  assign active   = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_adsr_env.sv
// Self-checking bench for adsr_env: table vectors plus long ADSR sequences, ce on every 4th clk.
module tb_adsr_env;

  localparam logic [2:0] P_IDLE = 3'd0, P_ATT = 3'd1, P_DEC = 3'd2, P_SUS = 3'd3, P_REL = 3'd4;

  typedef struct {
    logic        trig;
    logic [15:0] ai;
    logic [15:0] di;
    logic [7:0]  s;
    logic [15:0] ri;
    logic [7:0]  env;
    logic [7:0]  env_z;
    logic [2:0]  ph;
    logic        dn;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, ce, trig;
  logic [15:0] ai, di, ri;
  logic [7:0]  s;
  logic [7:0]  envelope, envelope_z;
  logic [2:0]  phase, phase_z;
  logic        active, active_z, done, done_z;

  int errors = 0;
  int checks = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  adsr_env #(.ENV_W(8), .FRAC_W(8), .RETRIG_ZERO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .trig(trig), .ai(ai), .di(di), .s(s), .ri(ri),
    .envelope(envelope), .phase(phase), .active(active), .done(done)
  );

  adsr_env #(.ENV_W(8), .FRAC_W(8), .RETRIG_ZERO(1'b1)) dut_z (
    .clk(clk), .rst_n(rst_n), .ce(ce), .trig(trig), .ai(ai), .di(di), .s(s), .ri(ri),
    .envelope(envelope_z), .phase(phase_z), .active(active_z), .done(done_z)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic t, input logic [15:0] a, input logic [15:0] d,
                              input logic [7:0] sv, input logic [15:0] r,
                              input logic [7:0] e, input logic [7:0] ez,
                              input logic [2:0] p, input logic dn);
    vec_t v;
    v.trig = t; v.ai = a; v.di = d; v.s = sv; v.ri = r;
    v.env = e; v.env_z = ez; v.ph = p; v.dn = dn;
    return v;
  endfunction

  // One ce step followed by three ce-low clocks; expectation goes through the scoreboard queue.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    trig = v.trig; ai = v.ai; di = v.di; s = v.s; ri = v.ri; ce = 1'b1;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("envelope", envelope, e.env);
    chk("phase", phase, e.ph);
    chk("active", active, e.ph != P_IDLE);
    chk("done", done, e.dn);
    chk("envelope_z", envelope_z, e.env_z);
    chk("phase_z", phase_z, e.ph);
    @(negedge clk);
    ce = 1'b0;
    @(posedge clk);
    #1;
    chk("done_one_clk", done, 1'b0);
    chk("hold_ce_low", envelope, e.env);
    @(posedge clk);
    @(posedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ce = 1'b0; trig = 1'b1;
    ai = '0; di = '0; s = '0; ri = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_envelope", envelope, 8'h00);
    chk("rst_phase", phase, P_IDLE);
    chk("rst_active", active, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Gate already high at reset release is a rise; then full ADSR cycle.
    step(mk(1, 16'h0500, 16'h0A00, 8'h40, 16'h0100, 8'h00, 8'h00, P_ATT, 0));
    for (int k = 1; k <= 52; k++) begin
      logic [31:0] a;
      a = k * 32'h500;
      if (k < 52) step(mk(1, 16'h0500, 16'h0A00, 8'h40, 16'h0100, a[15:8], a[15:8], P_ATT, 0));
      else        step(mk(1, 16'h0500, 16'h0A00, 8'h40, 16'h0100, 8'hFF, 8'hFF, P_DEC, 0));
    end
    for (int k = 1; k <= 20; k++) begin
      logic [31:0] a;
      a = 32'hFFFF - k * 32'hA00;
      if (k < 20) step(mk(1, 16'h0500, 16'h0A00, 8'h40, 16'h0100, a[15:8], a[15:8], P_DEC, 0));
      else        step(mk(1, 16'h0500, 16'h0A00, 8'h40, 16'h0100, 8'h40, 8'h40, P_SUS, 0));
    end
    for (int k = 0; k < 3; k++)
      step(mk(1, 16'h0500, 16'h0A00, 8'h40, 16'h0100, 8'h40, 8'h40, P_SUS, 0));
    step(mk(0, 16'h0500, 16'h0A00, 8'h40, 16'h0100, 8'h40, 8'h40, P_REL, 0));
    for (int k = 1; k <= 64; k++) begin
      logic [7:0] e;
      e = 8'h40 - 8'(k);
      if (k < 64) step(mk(0, 16'h0500, 16'h0A00, 8'h40, 16'h0100, e, e, P_REL, 0));
      else        step(mk(0, 16'h0500, 16'h0A00, 8'h40, 16'h0100, 8'h00, 8'h00, P_IDLE, 1));
    end
    chk("active_after_done", active, 1'b0);

    // Gate drops mid-attack at 0x80, re-raised mid-release.
    for (int k = 0; k <= 8; k++) begin
      logic [7:0] e;
      e = 8'(k * 16);
      step(mk(1, 16'h1000, 16'h0100, 8'h40, 16'h1000, e, e, P_ATT, 0));
    end
    step(mk(0, 16'h1000, 16'h0100, 8'h40, 16'h1000, 8'h80, 8'h80, P_REL, 0));
    step(mk(0, 16'h1000, 16'h0100, 8'h40, 16'h1000, 8'h70, 8'h70, P_REL, 0));
    step(mk(1, 16'h1000, 16'h0100, 8'h40, 16'h1000, 8'h70, 8'h00, P_ATT, 0));
    step(mk(1, 16'h1000, 16'h0100, 8'h40, 16'h1000, 8'h80, 8'h10, P_ATT, 0));
    step(mk(0, 16'h1000, 16'h0100, 8'h40, 16'h0000, 8'h80, 8'h10, P_REL, 0));
    step(mk(0, 16'h1000, 16'h0100, 8'h40, 16'h0000, 8'h00, 8'h00, P_IDLE, 1));

    // Zero rates, sustain extremes, exact saturation boundaries.
    tbl.push_back(mk(1, 16'h0000, 16'h0000, 8'h40, 16'h0000, 8'h00, 8'h00, P_ATT,  0));
    tbl.push_back(mk(1, 16'h0000, 16'h0000, 8'h40, 16'h0000, 8'hFF, 8'hFF, P_DEC,  0));
    tbl.push_back(mk(1, 16'h0000, 16'h0000, 8'h40, 16'h0000, 8'h40, 8'h40, P_SUS,  0));
    tbl.push_back(mk(1, 16'h0000, 16'h0000, 8'h55, 16'h0000, 8'h55, 8'h55, P_SUS,  0));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 8'h55, 16'h0000, 8'h55, 8'h55, P_REL,  0));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 8'h55, 16'h0000, 8'h00, 8'h00, P_IDLE, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 8'h55, 16'h0000, 8'h00, 8'h00, P_IDLE, 0));
    tbl.push_back(mk(1, 16'h8000, 16'h0100, 8'hFF, 16'h0100, 8'h00, 8'h00, P_ATT,  0));
    tbl.push_back(mk(1, 16'h8000, 16'h0100, 8'hFF, 16'h0100, 8'h80, 8'h80, P_ATT,  0));
    tbl.push_back(mk(1, 16'h8000, 16'h0100, 8'hFF, 16'h0100, 8'hFF, 8'hFF, P_DEC,  0));
    tbl.push_back(mk(1, 16'h8000, 16'h0100, 8'hFF, 16'h0100, 8'hFF, 8'hFF, P_SUS,  0));
    tbl.push_back(mk(1, 16'h8000, 16'h0100, 8'h00, 16'h0100, 8'h00, 8'h00, P_SUS,  0));
    tbl.push_back(mk(1, 16'h8000, 16'h0100, 8'h00, 16'h0100, 8'h00, 8'h00, P_SUS,  0));
    tbl.push_back(mk(0, 16'h8000, 16'h0100, 8'h00, 16'h0100, 8'h00, 8'h00, P_REL,  0));
    tbl.push_back(mk(0, 16'h8000, 16'h0100, 8'h00, 16'h0100, 8'h00, 8'h00, P_IDLE, 1));
    tbl.push_back(mk(1, 16'h7FFF, 16'hBFFF, 8'h40, 16'h3FFF, 8'h00, 8'h00, P_ATT,  0));
    tbl.push_back(mk(1, 16'h7FFF, 16'hBFFF, 8'h40, 16'h3FFF, 8'h7F, 8'h7F, P_ATT,  0));
    tbl.push_back(mk(1, 16'h7FFF, 16'hBFFF, 8'h40, 16'h3FFF, 8'hFF, 8'hFF, P_ATT,  0));
    tbl.push_back(mk(1, 16'h7FFF, 16'hBFFF, 8'h40, 16'h3FFF, 8'hFF, 8'hFF, P_DEC,  0));
    tbl.push_back(mk(1, 16'h7FFF, 16'hBFFF, 8'h40, 16'h3FFF, 8'h40, 8'h40, P_SUS,  0));
    tbl.push_back(mk(0, 16'h7FFF, 16'hBFFF, 8'h40, 16'h3FFF, 8'h40, 8'h40, P_REL,  0));
    tbl.push_back(mk(0, 16'h7FFF, 16'hBFFF, 8'h40, 16'h3FFF, 8'h00, 8'h00, P_REL,  0));
    tbl.push_back(mk(0, 16'h7FFF, 16'hBFFF, 8'h40, 16'h3FFF, 8'h00, 8'h00, P_IDLE, 1));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Asynchronous reset landing between clock edges while in DECAY.
    step(mk(1, 16'h0000, 16'h0100, 8'h40, 16'h0100, 8'h00, 8'h00, P_ATT, 0));
    step(mk(1, 16'h0000, 16'h0100, 8'h40, 16'h0100, 8'hFF, 8'hFF, P_DEC, 0));
    step(mk(1, 16'h0000, 16'h0100, 8'h40, 16'h0100, 8'hFE, 8'hFE, P_DEC, 0));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_envelope", envelope, 8'h00);
    chk("arst_phase", phase, P_IDLE);
    chk("arst_active", active, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_envelope_z", envelope_z, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(0, 16'h0000, 16'h0100, 8'h40, 16'h0100, 8'h00, 8'h00, P_IDLE, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
